ps2_kbd_port: RTL
=================

# ps2_kbd_port

PS/2 keyboard receiver that acts as the responder on the c8088 I/O port bus and the source of its keyboard interrupt. It deserialises PS/2 device-to-host frames into an 8-byte FIFO. Bytes are exposed at port 0x60 and status/control at port 0x64. A one-cycle `irq` pulse with vector `irq_in` fires per received byte. It sits in the de0 top level beside the CPU, with `port_i` merged into the CPU read mux via `port_hit`.

## Interface
- `DEPTH_LOG2`, 3: FIFO depth = 2^DEPTH_LOG2 entries.
- `TIMEOUT`, 2500: cycles with no PS/2 falling edge before a partial frame is abandoned (100 µs at 25 MHz).
- `VECTOR`, 8'h09: interrupt vector driven on `irq_in`.
- `DATA_PORT`, 16'h0060; `STAT_PORT`, 16'h0064.

Ports:
- `clock` in 1: system clock (clock_25 domain).
- `reset` in 1: synchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock (asynchronous).
- `ps2_dat` in 1: raw PS/2 data (asynchronous).
- `port_a` in 16: CPU port address.
- `port_r` in 1: CPU port read strobe, one cycle per access.
- `port_w` in 1: CPU port write strobe, one cycle per access.
- `port_o` in 8: CPU write data.
- `port_i` out 8: read data to CPU (combinational).
- `port_hit` out 1: `port_a` equals DATA_PORT or STAT_PORT (combinational).
- `irq` out 1: interrupt request pulse.
- `irq_in` out 8: interrupt vector, constant VECTOR.

## Operation
- Input conditioning:
  - Each of `ps2_clk` and `ps2_dat` passes through a 2-FF synchroniser.
  - `ps2_clk` is further filtered: the filtered level changes only after 4 consecutive identical synced samples.
  - Sample strobe = filtered clock 1→0.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe with dat=0 (start bit), go to DATA with bit count 0. A strobe with dat=1 is ignored.
  - DATA: shift dat in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: always return to IDLE. The byte is accepted only if stop=1 and data+parity has an odd count of ones. A bad parity bit or a stop bit of 0 sets PERR and discards the byte.
- Timeout: in any state other than IDLE, a counter reloads on each strobe. When TIMEOUT cycles elapse without a strobe, the FSM returns to IDLE, sets TERR, and discards the partial byte.
- FIFO push of an accepted byte:
  - If not full, push.
  - If full and a pop occurs in the same cycle, push (count unchanged).
  - Otherwise drop the byte and set OVF.
- Port read of DATA_PORT (`port_r`): `port_i` = FIFO head, or 8'h00 when empty. The head is popped on that clock edge if non-empty.
- Port read of STAT_PORT: `port_i` = {OVF, TERR, PERR, 2'b0, irq_en, 1'b0, not_empty}. This read does not clear anything.
- Port write to STAT_PORT (`port_w`):
  - bit0 → irq_en.
  - bit1=1 flushes the FIFO (count=0) on that edge. A push in the same cycle is lost.
  - bit2=1 clears OVF/TERR/PERR. A flag set in the same cycle wins.
- Port write to DATA_PORT is ignored.
- Other addresses: `port_i`=8'hFF, `port_hit`=0, no side effects.
- `irq` pulses high for exactly one cycle, in the cycle after a successful push, when irq_en=1. A dropped byte produces no pulse.

## Timing
- Reset values:
  - FSM IDLE; FIFO empty.
  - OVF=TERR=PERR=0; irq_en=1; `irq`=0.
  - Synchroniser and filter registers = 1.
  - `port_i`/`port_hit` follow their combinational rules.
  - `irq_in`=VECTOR at all times.
- Reset asserted mid-frame discards the partial byte and FIFO contents. The first frame after reset must begin with a fresh start bit.
- Sample strobe occurs 6–7 cycles after the raw `ps2_clk` falling edge.
- The STOP strobe edge writes the FIFO. The byte is readable on the next cycle; `irq` is high in that same next cycle.
- Head/pop update on the read edge. A back-to-back read on the next cycle sees the next entry.
- Simultaneous pop+push on an empty FIFO: the pop is a no-op and the push proceeds (read returns 8'h00).

## Test plan
- Single byte: frame 0x1C with correct parity and stop bit → `irq` pulse with `irq_in`=8'h09. Then read 0x64 = 8'h05, read 0x60 = 8'h1C, read 0x64 = 8'h04.
- Parity error: frame 0x1C with even parity → no push, no `irq`. Read 0x64 = 8'h24. Write 0x64 with 8'h05 → read 0x64 = 8'h04.
- Overflow: 9 frames 0x01..0x09 with no reads → read 0x64 = 8'h85. Eight reads of 0x60 return 0x01..0x08; a ninth returns 8'h00.
- Timeout: 5 bits of a frame, then 2600 idle cycles, then full frame 0x5A → TERR set. Only 0x5A is in the FIFO.
- Full-FIFO race: FIFO holds 8 entries; read 0x60 on the exact cycle the 9th byte (0xAA) is pushed → no OVF. The 8th subsequent read returns 0xAA.
- Control: write 0x64 with 8'h00, then receive 0x33 → no `irq`, byte stored. Write 8'h02 → 0x64 reads 8'h00. Reset asserted mid-frame, then a clean frame 0x44 → read 0x60 = 8'h44.

Source files
------------

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard receiver on the CPU port bus: bytes at DATA_PORT, status/control at STAT_PORT.
// Latency: byte readable and irq pulsed one cycle after the stop-bit strobe (~6 cycles after raw clk fall).
// Backpressure: none toward the keyboard; a byte arriving at a full FIFO without a same-cycle pop is dropped (OVF).
module ps2_kbd_port #(
    parameter int          DEPTH_LOG2 = 3,
    parameter int          TIMEOUT    = 2500,
    parameter logic [7:0]  VECTOR     = 8'h09,
    parameter logic [15:0] DATA_PORT  = 16'h0060,
    parameter logic [15:0] STAT_PORT  = 16'h0064
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic [15:0] port_a,
    input  logic        port_r,
    input  logic        port_w,
    input  logic [7:0]  port_o,
    output logic [7:0]  port_i,
    output logic        port_hit,
    output logic        irq,
    output logic [7:0]  irq_in
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Input conditioning
    logic       clk_s1, clk_s2, dat_s1, dat_s2;
    logic [2:0] clk_hist;
    logic       clk_filt;
    logic [3:0] clk_win;
    logic       strobe;

    assign clk_win = {clk_hist, clk_s2};
    assign strobe  = clk_filt && (clk_win == 4'h0);

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_hist <= 3'b111;
            clk_filt <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
            clk_hist <= {clk_hist[1:0], clk_s2};
            if (clk_win == 4'h0)
                clk_filt <= 1'b0;
            else if (clk_win == 4'hF)
                clk_filt <= 1'b1;
        end
    end

    // Frame FSM
    state_t          state, state_nxt;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic            par_bit;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo;
    logic            frame_done, frame_ok, frame_bad;

    assign tmo        = (state != S_IDLE) && !strobe && (tmo_cnt == TW'(TIMEOUT - 1));
    assign frame_done = strobe && (state == S_STOP);
    assign frame_ok   = frame_done && dat_s2 && (^{shreg, par_bit});
    assign frame_bad  = frame_done && !frame_ok;

    always_comb begin
        state_nxt = state;
        if (tmo) begin
            state_nxt = S_IDLE;
        end else if (strobe) begin
            case (state)
                S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE || strobe)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);
            if (strobe) begin
                case (state)
                    S_IDLE:   bit_cnt <= 3'd0;
                    S_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_bit <= dat_s2;
                    default:  ;
                endcase
            end
        end
    end

    // Port decode
    logic hit_data, hit_stat;
    logic rd_data, flush, clr_flags;

    assign hit_data  = (port_a == DATA_PORT);
    assign hit_stat  = (port_a == STAT_PORT);
    assign port_hit  = hit_data || hit_stat;
    assign rd_data   = port_r && hit_data;
    assign flush     = port_w && hit_stat && port_o[1];
    assign clr_flags = port_w && hit_stat && port_o[2];
    assign irq_in    = VECTOR;

    logic unused_bits;
    assign unused_bits = ^port_o[7:3];

    // Byte FIFO; a pop frees the slot for a same-edge push even when full
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  not_empty, full, pop, push, ovf_set;
    logic                  ovf, terr, perr, irq_en;

    assign not_empty = (count != '0);
    assign full      = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign pop       = rd_data && not_empty;
    assign push      = frame_ok && !flush && (!full || pop);
    assign ovf_set   = frame_ok && full && !pop;

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf    <= 1'b0;
            terr   <= 1'b0;
            perr   <= 1'b0;
            irq_en <= 1'b1;
            irq    <= 1'b0;
        end else begin
            irq <= push && irq_en;
            if (port_w && hit_stat)
                irq_en <= port_o[0];
            // Setting a flag beats a same-cycle clear
            if (ovf_set)        ovf <= 1'b1;
            else if (clr_flags) ovf <= 1'b0;
            if (tmo)            terr <= 1'b1;
            else if (clr_flags) terr <= 1'b0;
            if (frame_bad)      perr <= 1'b1;
            else if (clr_flags) perr <= 1'b0;
        end
    end

    always_comb begin
        port_i = 8'hFF;
        if (hit_data)
            port_i = not_empty ? mem[rd_ptr] : 8'h00;
        else if (hit_stat)
            port_i = {ovf, terr, perr, 2'b00, irq_en, 1'b0, not_empty};
    end

endmodule
